pixel_fetch_sequencer: RTL
==========================

# pixel_fetch_sequencer

Upstream feeder for the raw pixel shift register. Per active line it reads video bytes from memory over a request/acknowledge handshake and holds the next byte in a one-entry prefetch slot. It presents each byte on `Data` with a single-cycle `Load` strobe at a fixed byte period, and drives `Divider` for the line's pixel mode. It runs on the pixel clock and is started by the line and frame timing.

## Interface
- `BYTES_PER_LINE`, 32: bytes fetched and loaded per active line (≥1).
- `LEAD_CLKS`, 8: clocks from `LineStart` to the first `Load` (≥2).
- `ADDR_WIDTH`, 16: video address width.
- `Clk` in 1: pixel clock; all logic on the rising edge.
- `Reset` in 1: asynchronous, active-high.
- `LineStart` in 1: single-cycle pulse that begins an active line.
- `FrameStart` in 1: single-cycle pulse that reloads the address counter from `BaseAddr`.
- `BaseAddr` in `ADDR_WIDTH`: frame start address.
- `Mode2bpp` in 1: pixel mode, sampled on `LineStart`. 0 means 1bpp with an 8-clock byte period; 1 means 2bpp with a 4-clock byte period.
- `MemReq` out 1: read request.
- `MemAddr` out `ADDR_WIDTH`: read address, stable while `MemReq` is high.
- `MemAck` in 1: read complete; `MemData` is valid in this cycle.
- `MemData` in 8: read data.
- `Data` out 8: byte for the shifter.
- `Load` out 1: single-cycle load strobe.
- `Divider` out 1: mode latched for the current line.
- `Active` out 1: high during the line's active pixel period.
- `Underrun` out 1: sticky; set when a `Load` falls due with the slot empty.

## Operation
- States:
  - IDLE: waiting for `LineStart`.
  - LEAD: prefetching before the first `Load`.
  - ACTIVE: issuing `Load` strobes and fetching.
- IDLE→LEAD on `LineStart`:
  - Latch `Mode2bpp` into `Divider`.
  - Clear the lead counter, byte counter and slot.
- LEAD→ACTIVE once the lead counter reaches `LEAD_CLKS`.
- ACTIVE→IDLE after the last byte period (`BYTES_PER_LINE` periods) completes.
- Fetch rule (LEAD and ACTIVE):
  - While the slot is empty, no request is outstanding and fewer than `BYTES_PER_LINE` bytes have been requested, assert `MemReq` with `MemAddr` equal to the address counter.
  - Hold `MemReq` and `MemAddr` until `MemAck`.
  - On `MemAck`: write `MemData` into the slot, increment the address counter, and deassert `MemReq` the following cycle.
  - `MemAck` in the same cycle `MemReq` rises is legal.
  - `MemAck` without `MemReq` is ignored.
- Load rule:
  - At each byte-period boundary, pulse `Load` and set `Data` to the slot contents; the slot becomes empty.
  - If the slot empties in the same cycle as an ack, the ack refills it.
  - Slot empty at a boundary: `Data`=0x00, `Underrun` set. The byte count still advances, so the line never stretches.
- Address counter:
  - Wraps modulo 2^`ADDR_WIDTH`.
  - Not reset by `LineStart`, so consecutive lines read consecutive memory.
- `FrameStart`:
  - Honoured only in IDLE and ignored otherwise.
  - Simultaneous with `LineStart` in IDLE: the reload takes effect first, so the line fetches from `BaseAddr`.
- `LineStart` in LEAD or ACTIVE restarts the line (re-enter LEAD, relatch mode).
  - An outstanding request keeps `MemReq` high until its ack.
  - That acked byte is discarded and the address is still incremented.
  - After the discarded ack, fetch resumes under the normal fetch rule.
- `Underrun` is cleared only by `Reset`.

## Timing
- Reset values:
  - `MemReq`=0, `MemAddr`=0, `Data`=0x00, `Load`=0, `Divider`=0, `Active`=0, `Underrun`=0.
  - State IDLE, address counter 0.
- `LineStart` in cycle 0: the earliest `MemReq` is in cycle 1.
- Loads occur at cycles `LEAD_CLKS` + k·P for k = 0 … `BYTES_PER_LINE`−1, where P = 8 (1bpp) or 4 (2bpp).
- `Active` is high from cycle `LEAD_CLKS` through cycle `LEAD_CLKS` + `BYTES_PER_LINE`·P − 1; the block is in IDLE the cycle after.
- `Data` changes only in `Load` cycles and is held between them.
- All outputs are registered.

## Structure
- Shared package `vdg_pkg`:
  - State encoding (IDLE/LEAD/ACTIVE).
  - Byte-period constants (8, 4).
  - Mode bit names.
- Sub-module `prefetch_slot`:
  - One-entry buffer with valid flag.
  - Write on ack, read on `Load`, simultaneous read/write, discard flag.
- Top level: state machine, counters, handshake.

## Test plan
- Reset mid-ACTIVE with `MemReq` high → all outputs go to reset values immediately (asynchronously); the next `LineStart` starts cleanly from address 0.
- Defaults, 1bpp, zero-wait memory returning low address byte, `BaseAddr`=0x0400 with `FrameStart`+`LineStart` together at cycle 0:
  - 32 Loads at cycles 8, 16 … 256, with `Data` = 0x00 … 0x1F.
  - `Active` high 8–263.
  - `MemAddr` runs 0x0400–0x041F.
  - `Underrun`=0.
- 2bpp, same setup → Loads at 8, 12 … 132, `Divider`=1, `Active` high 8–135.
- `MemAck` delayed 10 clocks on the 3rd request → `Underrun`=1, that Load has `Data`=0x00, and the line still ends at cycle 263.
- `BaseAddr`=0xFFFE, 1bpp → `MemAddr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001 …; `FrameStart` pulsed during ACTIVE has no effect.
- `LineStart` during ACTIVE with a request outstanding:
  - `MemReq` holds until ack and that byte is never loaded.
  - The first Load follows 8 clocks after the restart pulse.

Source files
------------

// File: rtl/vdg_pkg.sv
// rtl/vdg_pkg.sv - shared state encoding and pixel-mode constants for the video fetch path
package vdg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } fetch_state_e;

  localparam int PERIOD_1BPP = 8;
  localparam int PERIOD_2BPP = 4;

  localparam logic MODE_1BPP = 1'b0;
  localparam logic MODE_2BPP = 1'b1;

  function automatic logic [2:0] last_phase(input logic mode);
    return (mode == MODE_2BPP) ? 3'(PERIOD_2BPP - 1) : 3'(PERIOD_1BPP - 1);
  endfunction

endpackage

// File: rtl/prefetch_slot.sv
// rtl/prefetch_slot.sv - one-entry byte buffer between the memory handshake and the load strobe
module prefetch_slot (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       arm_discard_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic       valid_q;
  logic       discard_q;
  logic [7:0] data_q;

  // A write in the same cycle as a read refills the slot; a pending discard swallows one write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      data_q    <= 8'h00;
    end else if (clr_i) begin
      valid_q   <= 1'b0;
      discard_q <= arm_discard_i;
    end else begin
      if (rd_en_i) valid_q <= 1'b0;
      if (wr_en_i) begin
        if (discard_q) begin
          discard_q <= 1'b0;
        end else begin
          valid_q <= 1'b1;
          data_q  <= wr_data_i;
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pixel_fetch_sequencer.sv
// rtl/pixel_fetch_sequencer.sv - per-line video byte fetch and timed load strobes for the pixel shifter
module pixel_fetch_sequencer
  import vdg_pkg::*;
#(
  parameter int BYTES_PER_LINE = 32,
  parameter int LEAD_CLKS      = 8,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  LineStart,
  input  logic                  FrameStart,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic                  Mode2bpp,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [7:0]            MemData,
  output logic [7:0]            Data,
  output logic                  Load,
  output logic                  Divider,
  output logic                  Active,
  output logic                  Underrun
);

  localparam int LW = $clog2(LEAD_CLKS + 1);
  localparam int BW = $clog2(BYTES_PER_LINE + 1);

  fetch_state_e          state_q, state_d;
  logic [LW-1:0]         lead_q, lead_d;
  logic [2:0]            phase_q, phase_d;
  logic [BW-1:0]         loaded_q, loaded_d;
  logic [BW-1:0]         reqd_q, reqd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  mreq_q, mreq_d;
  logic [7:0]            data_q, data_d;
  logic                  load_q, load_d;
  logic                  div_q, div_d;
  logic                  active_q, active_d;
  logic                  under_q, under_d;

  logic       ack;
  logic       do_load;
  logic       slot_clr;
  logic       slot_arm;
  logic       slot_valid;
  logic [7:0] slot_data;

  assign ack = mreq_q & MemAck;

  prefetch_slot u_slot (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .clr_i         (slot_clr),
    .arm_discard_i (slot_arm),
    .wr_en_i       (ack),
    .wr_data_i     (MemData),
    .rd_en_i       (do_load),
    .valid_o       (slot_valid),
    .data_o        (slot_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      lead_q   <= '0;
      phase_q  <= '0;
      loaded_q <= '0;
      reqd_q   <= '0;
      addr_q   <= '0;
      maddr_q  <= '0;
      mreq_q   <= 1'b0;
      data_q   <= 8'h00;
      load_q   <= 1'b0;
      div_q    <= MODE_1BPP;
      active_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lead_q   <= lead_d;
      phase_q  <= phase_d;
      loaded_q <= loaded_d;
      reqd_q   <= reqd_d;
      addr_q   <= addr_d;
      maddr_q  <= maddr_d;
      mreq_q   <= mreq_d;
      data_q   <= data_d;
      load_q   <= load_d;
      div_q    <= div_d;
      active_q <= active_d;
      under_q  <= under_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lead_d   = lead_q;
    phase_d  = phase_q;
    loaded_d = loaded_q;
    reqd_d   = reqd_q;
    addr_d   = addr_q;
    maddr_d  = maddr_q;
    mreq_d   = mreq_q;
    data_d   = data_q;
    load_d   = 1'b0;
    div_d    = div_q;
    active_d = active_q;
    under_d  = under_q;
    do_load  = 1'b0;
    slot_clr = 1'b0;
    slot_arm = 1'b0;

    if (ack) begin
      mreq_d = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    if (FrameStart && state_q == ST_IDLE) addr_d = BaseAddr;

    unique case (state_q)
      ST_LEAD: begin
        if (lead_q == LW'(LEAD_CLKS - 1)) begin
          state_d  = ST_ACTIVE;
          active_d = 1'b1;
          phase_d  = '0;
          loaded_d = BW'(1);
          do_load  = 1'b1;
        end else begin
          lead_d = lead_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (phase_q == last_phase(div_q)) begin
          if (loaded_q == BW'(BYTES_PER_LINE)) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end else begin
            loaded_d = loaded_q + 1'b1;
            phase_d  = '0;
            do_load  = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (do_load) begin
      load_d = 1'b1;
      data_d = slot_valid ? slot_data : 8'h00;
      if (!slot_valid) under_d = 1'b1;
    end

    if (state_d != ST_IDLE && !slot_valid && !mreq_q && reqd_q < BW'(BYTES_PER_LINE)) begin
      mreq_d  = 1'b1;
      maddr_d = addr_q;
      reqd_d  = reqd_q + 1'b1;
    end

    // A restart cancels any load due this edge; an in-flight read completes but its byte is dropped.
    if (LineStart) begin
      state_d  = ST_LEAD;
      div_d    = Mode2bpp;
      lead_d   = LW'(1);
      phase_d  = '0;
      loaded_d = '0;
      active_d = 1'b0;
      load_d   = 1'b0;
      data_d   = data_q;
      under_d  = under_q;
      slot_clr = 1'b1;
      if (mreq_q) begin
        reqd_d   = '0;
        slot_arm = !MemAck;
      end else begin
        mreq_d  = 1'b1;
        maddr_d = addr_d;
        reqd_d  = BW'(1);
      end
    end
  end

  assign MemReq   = mreq_q;
  assign MemAddr  = maddr_q;
  assign Data     = data_q;
  assign Load     = load_q;
  assign Divider  = div_q;
  assign Active   = active_q;
  assign Underrun = under_q;

endmodule
